// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for the imem loader.
// Latency: none (wires only).  Backpressure: byte stream is valid/ready; the write port has none.
// Ports: byte_valid/byte_data/byte_ready (stream), mem_we/mem_addr/mem_wdata (memory write port).
interface imem_loader_if #(
  parameter int M = 32
);
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         mem_we;
  logic [M-1:0] mem_addr;
  logic [M-1:0] mem_wdata;

  // master: byte source that also observes the memory write port
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // slave: the loader, which sinks bytes and drives the memory write port
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit words from a byte stream into instruction memory, holding the core in reset.
// Latency: start to done is 5n+1 cycles for n words on a continuous stream (4 accepts + 1 write per word).
// Backpressure: byte_ready is high only in COLLECT; a stalled stream simply holds state, no timeout.
// Ports: clk, rst_n; start/num_words request a load; bus carries the byte stream and memory write port;
//        busy/cpu_hold are high during COLLECT and WRITE; done pulses for one cycle at completion.
module imem_loader #(
  parameter int N  = 64,
  parameter int M  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [CW-1:0]  num_words,
  imem_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           cpu_hold
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [CW-1:0] N_MAX = CW'(N);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  target;
  logic [CW-1:0]  index;
  logic [CW-1:0]  index_inc;
  logic [1:0]     byte_cnt;
  logic [23:0]    asm_q;     // first three bytes of the word being assembled
  logic           accept;

  assign index_inc = index + 1'b1;
  assign accept    = bus.byte_valid && (state == COLLECT);
  assign cpu_hold  = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // All outputs decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt      = state;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_words == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        // target is clamped to N, so the last written index is at most N-1
        state_nxt  = (index_inc == target) ? DONE : COLLECT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_wdata load only on the 4th byte of a word, so they stay stable
  // through WRITE and keep their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target        <= '0;
      index         <= '0;
      byte_cnt      <= '0;
      asm_q         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && num_words != '0) begin
            target   <= (num_words > N_MAX) ? N_MAX : num_words;
            index    <= '0;
            byte_cnt <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], bus.byte_data};
            if (byte_cnt == 2'd3) begin
              bus.mem_addr  <= M'(index) << 2;
              bus.mem_wdata <= M'({asm_q, bus.byte_data});
            end
          end
        end
        WRITE: begin
          index    <= index_inc;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected memory writes plus per-scenario timing checks.
// Latency: n/a.  Backpressure: the byte source waits on byte_ready with a bounded cycle budget.
// Ports: none; drives the loader through imem_loader_if and the plain control ports.
module tb_imem_loader;
  localparam int N  = 64;
  localparam int M  = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          busy;
  logic          done;
  logic          cpu_hold;

  imem_loader_if #(.M(M)) bus ();

  imem_loader #(.N(N), .M(M), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .cpu_hold  (cpu_hold)
  );

  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          st_cyc    = 0;
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  int          busy_cnt  = 0;
  int          done_cyc  = 0;
  logic [63:0] sb[$];
  int          wr_cyc[$];
  logic [63:0] exp_w;
  logic [M-1:0] last_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Write monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      last_addr = bus.mem_addr;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%h data=%h, required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_w = sb.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    checks++;
    if (cpu_hold !== busy) begin
      errors++;
      $display("FAIL cpu_hold_eq_busy: got cpu_hold=%b busy=%b at cycle %0d", cpu_hold, busy, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = CW'(n);
    st_cyc    = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte=%h byte_ready=%b, required 1 within 40 cycles", b, bus.byte_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    sb.push_back({addr, w});
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no done pulse within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.byte_ready, bus.mem_we, busy, done, cpu_hold} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/we/busy/done/hold=%b, required 00000",
               {bus.byte_ready, bus.mem_we, busy, done, cpu_hold});
    end
    checks++;
    if (bus.mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h, required 0", bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_wdata: got %h, required 0", bus.mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int b0 = busy_cnt;
    do_start(1);
    checks++;
    if ({busy, bus.byte_ready} !== 2'b11) begin
      errors++;
      $display("FAIL single_start_latency: got busy/rdy=%b, required 11", {busy, bus.byte_ready});
    end
    send_word(32'h0, 32'h8C01_0004);
    bus.byte_valid = 1'b0;
    wait_done(d0, 20);
    checks++;
    if (done_cyc - st_cyc != 6) begin
      errors++;
      $display("FAIL single_done_cycle: got %0d, required 6", done_cyc - st_cyc);
    end
    checks++;
    if (wr_cnt - w0 != 1) begin
      errors++;
      $display("FAIL single_writes: got %0d, required 1", wr_cnt - w0);
    end
    checks++;
    if (busy_cnt - b0 != 5) begin
      errors++;
      $display("FAIL single_busy_cycles: got %0d, required 5", busy_cnt - b0);
    end
    checks++;
    if ({busy, done, bus.byte_ready} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: got busy/done/rdy=%b, required 000", {busy, done, bus.byte_ready});
    end
    checks++;
    if (bus.mem_wdata !== 32'h8C01_0004) begin
      errors++;
      $display("FAIL single_wdata_hold: got %h, required 8c010004", bus.mem_wdata);
    end
  endtask

  task automatic test_three();
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int b0 = busy_cnt;
    int k0 = wr_cyc.size();
    do_start(3);
    for (int i = 0; i < 3; i++) send_word(32'(i * 4), $urandom);
    bus.byte_valid = 1'b0;
    wait_done(d0, 40);
    checks++;
    if (done_cyc - st_cyc != 16) begin
      errors++;
      $display("FAIL three_done_cycle: got %0d, required 16", done_cyc - st_cyc);
    end
    checks++;
    if (wr_cnt - w0 != 3) begin
      errors++;
      $display("FAIL three_writes: got %0d, required 3", wr_cnt - w0);
    end
    checks++;
    if (busy_cnt - b0 != 15) begin
      errors++;
      $display("FAIL three_busy_cycles: got %0d, required 15", busy_cnt - b0);
    end
    for (int i = 0; i < 3 && k0 + i < wr_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[k0 + i] - st_cyc != 5 * (i + 1)) begin
        errors++;
        $display("FAIL three_write_cycle: word %0d got %0d, required %0d", i, wr_cyc[k0 + i] - st_cyc, 5 * (i + 1));
      end
    end
  endtask

  task automatic test_stall();
    int d0 = done_cnt;
    do_start(1);
    sb.push_back({32'h0, 32'h2008_0005});
    send_byte(8'h20);
    send_byte(8'h08);
    bus.byte_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.byte_ready, bus.mem_we} !== 2'b10) begin
        errors++;
        $display("FAIL stall_hold: got rdy/we=%b, required 10", {bus.byte_ready, bus.mem_we});
      end
      @(posedge clk);
      #1;
    end
    send_byte(8'h00);
    send_byte(8'h05);
    bus.byte_valid = 1'b0;
    wait_done(d0, 20);
    checks++;
    if (done_cyc - st_cyc != 9) begin
      errors++;
      $display("FAIL stall_done_cycle: got %0d, required 9", done_cyc - st_cyc);
    end
  endtask

  task automatic test_zero();
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int b0 = busy_cnt;
    do_start(0);
    wait_done(d0, 10);
    checks++;
    if (done_cyc - st_cyc != 1) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d, required 1", done_cyc - st_cyc);
    end
    checks++;
    if ((wr_cnt - w0) != 0 || (busy_cnt - b0) != 0) begin
      errors++;
      $display("FAIL zero_activity: got writes=%0d busy=%0d, required 0 and 0", wr_cnt - w0, busy_cnt - b0);
    end
  endtask

  task automatic test_oversize();
    int d0 = done_cnt;
    int w0 = wr_cnt;
    do_start(100);
    for (int i = 0; i < N; i++) send_word(32'(i * 4), $urandom);
    bus.byte_data = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL oversize_no_accept: got byte_ready=%b after 256 bytes, required 0", bus.byte_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    wait_done(d0, 20);
    checks++;
    if (done_cyc - st_cyc != 5 * N + 1) begin
      errors++;
      $display("FAIL oversize_done_cycle: got %0d, required %0d", done_cyc - st_cyc, 5 * N + 1);
    end
    checks++;
    if (wr_cnt - w0 != N) begin
      errors++;
      $display("FAIL oversize_writes: got %0d, required %0d", wr_cnt - w0, N);
    end
    checks++;
    if (last_addr !== 32'hFC) begin
      errors++;
      $display("FAIL oversize_last_addr: got %h, required 000000fc", last_addr);
    end
  endtask

  task automatic test_start_busy();
    int d0 = done_cnt;
    int w0 = wr_cnt;
    do_start(2);
    send_word(32'h0, $urandom);
    start     = 1'b1;
    num_words = CW'(5);
    tick();
    start     = 1'b0;
    send_word(32'h4, $urandom);
    bus.byte_valid = 1'b0;
    wait_done(d0, 40);
    checks++;
    if (done_cyc - st_cyc != 11) begin
      errors++;
      $display("FAIL busy_start_done_cycle: got %0d, required 11", done_cyc - st_cyc);
    end
    repeat (8) tick();
    checks++;
    if (wr_cnt - w0 != 2 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got writes=%0d dones=%0d busy=%b, required 2 1 0",
               wr_cnt - w0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    int d0;
    do_start(4);
    send_word(32'h0, $urandom);
    send_word(32'h4, $urandom);
    send_byte(8'h3C);
    send_byte(8'h1D);
    bus.byte_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.byte_ready, bus.mem_we, busy, done, cpu_hold} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy/we/busy/done/hold=%b addr=%h data=%h, required all 0",
               {bus.byte_ready, bus.mem_we, busy, done, cpu_hold}, bus.mem_addr, bus.mem_wdata);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_cnt - w0 != 2) begin
      errors++;
      $display("FAIL midreset_writes: got %0d, required 2", wr_cnt - w0);
    end
    d0 = done_cnt;
    do_start(1);
    send_word(32'h0, 32'h0C00_0010);
    bus.byte_valid = 1'b0;
    wait_done(d0, 20);
    checks++;
    if (done_cyc - st_cyc != 6) begin
      errors++;
      $display("FAIL midreset_reload_done: got %0d, required 6", done_cyc - st_cyc);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    test_reset();
    test_single();
    test_three();
    test_stall();
    test_zero();
    test_oversize();
    test_start_busy();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the pipelined MIPS core. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word-aligned addresses of the instruction memory's write port. It holds the processor in reset while loading. It is the writer-side counterpart of the instruction fetch path, so programs can be loaded at run time instead of only from the initial memory image.

## Interface
- N, 64, instruction memory depth in words
- M, 32, word and address width
- CW, $clog2(N+1), word-count width (7 for N=64)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- num_words  in  CW  number of words to load; sampled with start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  next program byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  M  byte address of the write, always word-aligned (index<<2)
- mem_wdata  out  M  assembled instruction word
- busy  out  1  load in progress (COLLECT or WRITE)
- done  out  1  one-cycle pulse when a load completes
- cpu_hold  out  1  keeps the core in reset; equals busy

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0.
  - On start with num_words==0: go to DONE.
  - On start with num_words>0: latch the target count as min(num_words, N), clear the word index and byte counter, and go to COLLECT.
- COLLECT: byte_ready=1. A byte transfers when byte_valid && byte_ready.
  - Byte 0 fills [31:24], byte 1 fills [23:16], byte 2 fills [15:8], byte 3 fills [7:0].
  - After the 4th byte, go to WRITE.
  - When byte_valid is low, the state and contents are held; no timeout.
- WRITE: byte_ready=0, mem_we=1, mem_addr=index<<2, mem_wdata=assembled word.
  - Then increment the index and clear the byte counter.
  - If the new index equals the target count, go to DONE; otherwise go back to COLLECT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored and has no side effects.
- The index never exceeds N-1, so writes never wrap past the top of memory. Bytes beyond the clamped count are not accepted.
- mem_addr and mem_wdata are don't-care when mem_we=0, but they hold their last value; they do not toggle freely.
- Reset:
  - All state clears and the state goes to IDLE.
  - byte_ready, mem_we, busy, done and cpu_hold are all 0.
  - mem_addr and mem_wdata are 0.
  - A partial word is discarded. Words already written stay in memory.

## Timing
- All outputs are registered or decoded from the registered state, with no combinational path from inputs to outputs.
- start at edge k: state is COLLECT and busy=1 from edge k+1. byte_ready is first high in cycle k+1.
- With byte_valid held high, each word takes 4 accept cycles plus 1 WRITE cycle, so one word is written every 5 cycles.
- n words with a continuous stream: from the start edge to the done pulse is 5n+1 cycles. done is high in the cycle after the last WRITE.
- num_words==0: done is high in the cycle after start, and busy stays 0.
- cpu_hold deasserts in the same cycle done asserts.
- Asynchronous reset takes effect immediately. The first start can be accepted on the first clock edge after rst_n deasserts.

## Test plan
- **Single word:** reset, then start with num_words=1 and bytes 8C,01,00,04. Required: one write with mem_addr=0x0, mem_wdata=0x8C010004, done at cycle 6 after start, then IDLE.
- **Three words, continuous stream:** start with num_words=3. Required: writes at mem_addr 0x0, 0x4, 0x8 every 5 cycles, done 16 cycles after start, busy and cpu_hold high throughout.
- **Stalled stream:** byte_valid low for 3 cycles between bytes 1 and 2 of word 0. Required: byte_ready stays 1, no write occurs, and the word assembles correctly (0x20080005) with completion delayed by exactly 3 cycles.
- **Zero and oversize counts:**
  - num_words=0: done pulse on the next cycle, no mem_we.
  - num_words=100 with N=64: exactly 64 writes, last mem_addr=0xFC, and byte_ready=0 after the 256th byte.
- **Start during a load:** pulse start again while busy, with num_words=5. Required: ignored; the original count completes unchanged.
- **Reset mid-load:** assert rst_n low after word 1 is written and 2 bytes of word 2 are accepted. Required: all outputs are 0 immediately, no further mem_we, and a new load afterwards starts again at mem_addr=0x0.
